// File: rtl/p0_serial_tx_if.sv
// Write-side bus between the P0 output port and the serial transmitter.
//   wr_en/wr_data : one word per high cycle, driven by the core side
//   full/count    : FIFO occupancy; count excludes the word being shifted
//   overflow      : sticky flag set when a write is dropped
interface p0_serial_tx_if #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              full;
  logic [CW-1:0]     count;
  logic              overflow;

  modport master (output wr_en, wr_data, input full, count, overflow);
  modport slave  (input wr_en, wr_data, output full, count, overflow);
endinterface

// File: rtl/p0_serial_tx.sv
// P0 serial transmitter: buffers P0 writes in a DEPTH-entry FIFO and shifts
// each word out as start bit, DATA_W data bits LSB first, stop bit, with DIV
// clocks per bit. Back-to-back frames follow with no idle gap.
//   clk  : system clock (rising edge)
//   rst  : asynchronous active-low reset
//   bus  : write side (wr_en, wr_data in; full, count, overflow out)
//   busy : high whenever the framer is not idle (registered)
//   tx   : serial line, idles high (registered)
module p0_serial_tx #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4,
  parameter int DIV    = 8
) (
  input  logic             clk,
  input  logic             rst,
  p0_serial_tx_if.slave    bus,
  output logic             busy,
  output logic             tx
);
  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int DVW = $clog2(DIV);
  localparam int BW  = $clog2(DATA_W);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count_q;
  logic              ovf_q;

  state_t            state, state_n;
  logic [DVW-1:0]    div_q, div_n;
  logic [BW-1:0]     bit_q, bit_n;
  logic [DATA_W-1:0] shift_q, shift_n;
  logic              tx_n, busy_n;
  logic              pop, push, full_w, div_last;

  // full comes from registered occupancy only, so a pop on the same edge
  // never frees room for a write that arrives while full.
  assign full_w   = (count_q == CW'(DEPTH));
  assign push     = bus.wr_en && !full_w;
  assign div_last = (div_q == DVW'(DIV - 1));

  assign bus.full     = full_w;
  assign bus.count    = count_q;
  assign bus.overflow = ovf_q;

  // ---------------- FIFO ----------------
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (bus.wr_en && full_w) ovf_q <= 1'b1;
    end
  end

  // ---------------- framer FSM ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx      <= 1'b1;
      busy    <= 1'b0;
    end else begin
      state   <= state_n;
      div_q   <= div_n;
      bit_q   <= bit_n;
      shift_q <= shift_n;
      tx      <= tx_n;
      busy    <= busy_n;
    end
  end

  always_comb begin
    state_n = state;
    div_n   = div_q;
    bit_n   = bit_q;
    shift_n = shift_q;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        div_n = '0;
        if (count_q != '0) begin
          pop     = 1'b1;
          shift_n = mem[rd_ptr];
          bit_n   = '0;
          state_n = START;
        end
      end
      START: begin
        div_n = div_last ? '0 : div_q + DVW'(1);
        if (div_last) begin
          bit_n   = '0;
          state_n = DATA;
        end
      end
      DATA: begin
        div_n = div_last ? '0 : div_q + DVW'(1);
        if (div_last) begin
          shift_n = shift_q >> 1;
          if (bit_q == BW'(DATA_W - 1)) state_n = STOP;
          else                          bit_n   = bit_q + BW'(1);
        end
      end
      STOP: begin
        div_n = div_last ? '0 : div_q + DVW'(1);
        if (div_last) begin
          // Chain straight into the next frame when a word is waiting.
          if (count_q != '0) begin
            pop     = 1'b1;
            shift_n = mem[rd_ptr];
            bit_n   = '0;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Registered outputs are derived from the next state so tx/busy line up
  // with the state they describe.
  always_comb begin
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_n[0];
      default: tx_n = 1'b1;
    endcase
    busy_n = (state_n != IDLE);
  end
endmodule

// File: tb/tb_p0_serial_tx.sv
module tb_p0_serial_tx;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 4;
  localparam int DIV    = 4;
  localparam int FRAME  = (DATA_W + 2) * DIV;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic busy, tx;

  p0_serial_tx_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  p0_serial_tx #(.DATA_W(DATA_W), .DEPTH(DEPTH), .DIV(DIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .busy(busy),
    .tx  (tx)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [DATA_W-1:0] exp_q[$];
  int ncyc = 0;
  int last_start = -1;
  int prev_start = -1;

  // Receiver: decodes frames from tx (mid-bit sampling) and checks them
  // against the scoreboard in write order.
  initial begin : monitor
    bit in_frame = 1'b0;
    int mc = 0;
    logic [DATA_W-1:0] rx = '0;
    logic [DATA_W-1:0] e;
    forever begin
      @(negedge clk);
      ncyc++;
      if (!rst) begin
        in_frame = 1'b0;
      end else if (!in_frame) begin
        if (tx === 1'b0) begin
          in_frame = 1'b1;
          mc = 0;
          rx = '0;
          prev_start = last_start;
          last_start = ncyc;
        end
      end else begin
        mc++;
        if (mc == DIV / 2) begin
          total++;
          if (tx !== 1'b0) begin bad++; $display("FAIL mon_start: tx=%b want 0", tx); end
        end
        if (mc >= DIV && mc < (DATA_W + 1) * DIV && (mc % DIV) == DIV / 2)
          rx[(mc - DIV) / DIV] = tx;
        if (mc == (DATA_W + 1) * DIV + DIV / 2) begin
          total++;
          if (tx !== 1'b1) begin bad++; $display("FAIL mon_stop: tx=%b want 1", tx); end
        end
        if (mc == FRAME - 1) begin
          in_frame = 1'b0;
          total++;
          if (exp_q.size() == 0) begin
            bad++; $display("FAIL mon_unexpected: got frame %h want none", rx);
          end else begin
            e = exp_q.pop_front();
            if (rx !== e) begin bad++; $display("FAIL mon_word: got %h want %h", rx, e); end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #(60000 * 10);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst = 1'b0;
    bus.wr_en = 1'b0;
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_drain(input int limit);
    int n = 0;
    while ((busy || bus.count != '0) && n < limit) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (busy || bus.count != '0) begin
      bad++; $display("FAIL drain_timeout: busy=%b count=%0d want 0/0", busy, bus.count);
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL drain_missing: %0d words unsent want 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    bit ok = 1'b1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      total++;
      if ({tx, busy, bus.count, bus.full, bus.overflow} !== {1'b1, 1'b0, 3'd0, 1'b0, 1'b0}) begin
        bad++;
        $display("FAIL reset_hold: tx=%b busy=%b count=%0d full=%b ovf=%b want 1 0 0 0 0",
                 tx, busy, bus.count, bus.full, bus.overflow);
      end
      bus.wr_en   = i[0];
      bus.wr_data = DATA_W'($urandom);
    end
    bus.wr_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || bus.count !== 3'd0) ok = 1'b0;
    end
    total++;
    if (!ok) begin bad++; $display("FAIL reset_release: line not idle got 0 want 1"); end
  endtask

  task automatic test_single();
    logic [DATA_W-1:0] d = 16'hF0F0;
    logic exp_tx;
    bus.wr_en = 1'b1; bus.wr_data = d; exp_q.push_back(d);
    @(negedge clk);                       // after edge N
    bus.wr_en = 1'b0;
    total++;
    if (bus.count !== 3'd1 || tx !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL single_n: count=%0d tx=%b busy=%b want 1 1 0", bus.count, tx, busy);
    end
    @(negedge clk);                       // after edge N+1
    total++;
    if (bus.count !== 3'd0 || busy !== 1'b1) begin
      bad++; $display("FAIL single_n1: count=%0d busy=%b want 0 1", bus.count, busy);
    end
    for (int k = 0; k < FRAME; k++) begin
      if (k < DIV)                        exp_tx = 1'b0;
      else if (k < (DATA_W + 1) * DIV)    exp_tx = d[(k - DIV) / DIV];
      else                                exp_tx = 1'b1;
      total++;
      if (tx !== exp_tx) begin bad++; $display("FAIL single_tx[%0d]: tx=%b want %b", k, tx, exp_tx); end
      @(negedge clk);
    end
    total++;
    if (busy !== 1'b0 || tx !== 1'b1) begin
      bad++; $display("FAIL single_end: busy=%b tx=%b want 0 1", busy, tx);
    end
    wait_drain(10);
  endtask

  task automatic test_back_to_back();
    bus.wr_en = 1'b1; bus.wr_data = 16'h0001; exp_q.push_back(16'h0001);
    @(negedge clk);
    bus.wr_data = 16'h8000; exp_q.push_back(16'h8000);
    @(negedge clk);
    bus.wr_en = 1'b0;
    wait_drain(3 * FRAME);
    total++;
    if (last_start - prev_start != FRAME) begin
      bad++; $display("FAIL b2b_gap: start spacing=%0d want %0d", last_start - prev_start, FRAME);
    end
  endtask

  task automatic test_simul_pop();
    bus.wr_en = 1'b1; bus.wr_data = 16'hA1A1; exp_q.push_back(16'hA1A1);
    @(negedge clk);                       // after N
    bus.wr_en = 1'b0;
    repeat (4) @(negedge clk);            // after N+4
    bus.wr_en = 1'b1; bus.wr_data = 16'hB2B2; exp_q.push_back(16'hB2B2);
    @(negedge clk);                       // after N+5
    bus.wr_en = 1'b0;
    repeat (67) @(negedge clk);           // after N+72
    total++;
    if (bus.count !== 3'd1) begin bad++; $display("FAIL simul_pre: count=%0d want 1", bus.count); end
    bus.wr_en = 1'b1; bus.wr_data = 16'hC3C3; exp_q.push_back(16'hC3C3);
    @(negedge clk);                       // after N+73: pop and push together
    bus.wr_en = 1'b0;
    total++;
    if (bus.count !== 3'd1 || tx !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL simul_pop: count=%0d tx=%b busy=%b want 1 0 1", bus.count, tx, busy);
    end
    wait_drain(4 * FRAME);
  endtask

  task automatic test_simul_full();
    logic [DATA_W-1:0] w [5] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      bus.wr_en = 1'b1; bus.wr_data = w[i]; exp_q.push_back(w[i]);
      @(negedge clk);
    end                                   // after N+4
    bus.wr_en = 1'b0;
    total++;
    if (bus.full !== 1'b1 || bus.count !== 3'd4 || bus.overflow !== 1'b0) begin
      bad++; $display("FAIL sfull_fill: full=%b count=%0d ovf=%b want 1 4 0", bus.full, bus.count, bus.overflow);
    end
    repeat (68) @(negedge clk);           // after N+72
    bus.wr_en = 1'b1; bus.wr_data = 16'h6666;
    @(negedge clk);                       // after N+73: rejected write, pop happens
    bus.wr_en = 1'b0;
    total++;
    if (bus.overflow !== 1'b1 || bus.count !== 3'd3 || bus.full !== 1'b0 || tx !== 1'b0) begin
      bad++; $display("FAIL sfull_rej: ovf=%b count=%0d full=%b tx=%b want 1 3 0 0",
                      bus.overflow, bus.count, bus.full, tx);
    end
    wait_drain(6 * FRAME);
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      bus.wr_en = 1'b1; bus.wr_data = DATA_W'(16'hD000 + i);
      if (i < 5) exp_q.push_back(DATA_W'(16'hD000 + i));
      @(negedge clk);
      if (i == 4) begin
        total++;
        if (bus.full !== 1'b1 || bus.count !== 3'd4 || bus.overflow !== 1'b0) begin
          bad++; $display("FAIL ovf_fill: full=%b count=%0d ovf=%b want 1 4 0", bus.full, bus.count, bus.overflow);
        end
      end
    end
    bus.wr_en = 1'b0;
    total++;
    if (bus.overflow !== 1'b1 || bus.count !== 3'd4) begin
      bad++; $display("FAIL ovf_set: ovf=%b count=%0d want 1 4", bus.overflow, bus.count);
    end
    wait_drain(6 * FRAME);
    total++;
    if (bus.overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky: ovf=%b want 1", bus.overflow); end
  endtask

  task automatic test_reset_mid();
    bit ok = 1'b1;
    do_reset();
    bus.wr_en = 1'b1; bus.wr_data = 16'h1234; exp_q.push_back(16'h1234);
    @(negedge clk);
    bus.wr_data = 16'h5678;
    @(negedge clk);
    bus.wr_data = 16'h9ABC;
    @(negedge clk);                       // after N+2
    bus.wr_en = 1'b0;
    repeat (33) @(negedge clk);           // after N+35: mid data bit 7 (a zero)
    total++;
    if (tx !== 1'b0 || bus.count !== 3'd2) begin
      bad++; $display("FAIL rmid_pre: tx=%b count=%0d want 0 2", tx, bus.count);
    end
    rst = 1'b0;
    exp_q.delete();
    #1;
    total++;
    if (tx !== 1'b1 || bus.count !== 3'd0 || busy !== 1'b0) begin
      bad++; $display("FAIL rmid_async: tx=%b count=%0d busy=%b want 1 0 0", tx, bus.count, busy);
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3 * FRAME; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) ok = 1'b0;
    end
    total++;
    if (!ok) begin bad++; $display("FAIL rmid_after: discarded words sent, tx low got 0 want 1"); end
  endtask

  initial begin
    bus.wr_en   = 1'b0;
    bus.wr_data = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_simul_pop();
    test_simul_full();
    test_overflow();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/p0_serial_tx.md
Name: p0_serial_tx

Overview:
- Downstream consumer of the microcontroller's 16-bit P0 output port.
- Each word written to P0 is captured into a small FIFO, then shifted out on a single serial line.
- Frame format: start bit, 16 data bits LSB first, stop bit. Bit period is a fixed number of clocks.
- Sits between the core's P0_data_out/write strobe and the board pin. Decouples core write bursts from the slow serial rate.

Parameters:
- DATA_W, 16, word width; matches P0 width.
- DEPTH, 4, FIFO entries; must be a power of two, at least 2.
- DIV, 8, clocks per serial bit; at least 2.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-low (0 = reset).
- wr_en  input  1  P0 write strobe; one word per high cycle.
- wr_data  input  DATA_W  word from P0_data_out.
- full  output  1  FIFO holds DEPTH words.
- count  output  $clog2(DEPTH)+1  words currently buffered; excludes the word being shifted.
- busy  output  1  high whenever the FSM is not in IDLE.
- overflow  output  1  sticky; set when a write is rejected.
- tx  output  1  serial line; idles high.

Behaviour:
- Reset (rst=0, asynchronous): count=0, full=0, busy=0, overflow=0, tx=1. FSM goes to IDLE. FIFO pointers, bit counter, divider and shift register are cleared.
  - Asserting reset mid-frame aborts the frame; tx returns to 1 without waiting for a clock.
  - Buffered words are discarded.
- FIFO write:
  - Accepted at the edge where wr_en=1 and full=0. wr_data is stored and count increments at that edge.
  - If wr_en=1 and full=1, the write is rejected and overflow is set to 1 at that edge. This holds even if a pop occurs in the same cycle; full is evaluated from the registered state.
  - overflow clears only on reset.
  - Push and pop on the same edge: count is unchanged and both pointers advance.
  - Pointers wrap modulo DEPTH.
  - full = (count==DEPTH).
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1, busy=0. If count>0 at an edge: pop the head word into the shift register, clear the divider, go to START.
  - A word written at edge N therefore pops at edge N+1. tx falls after edge N+1.
  - START: tx=0 for DIV clocks, then go to DATA with bit index 0.
  - DATA: tx=shift[0] for DIV clocks per bit, then shift right and increment the bit index. After DATA_W bits, go to STOP.
  - STOP: tx=1 for DIV clocks.
    - At the final edge, if count>0, pop the next word and go directly to START (no idle gap).
    - Otherwise go to IDLE.
- Frame length: exactly (DATA_W+2)*DIV clocks; 144 clocks at the defaults.
- The divider counts 0..DIV-1. A state or bit advance occurs at the edge where the divider equals DIV-1, and the divider wraps to 0 at that edge.
- tx and busy are registered outputs; they do not glitch when inputs change.
- wr_en is ignored during reset.

Test Plan:
- Reset check: hold rst=0, toggle wr_en with data.
  -> tx=1, busy=0, count=0, full=0, overflow=0 throughout.
  -> After release, tx stays 1 with no writes.
- Single word: DIV=4, write 16'hF0F0 at edge N.
  -> count=1 after N, 0 after N+1.
  -> tx=0 for 4 clocks.
  -> tx bits LSB first: 0000 1111 0000 1111, each 4 clocks.
  -> tx=1 for 4 clocks; busy drops after 72 clocks total.
- Back-to-back: write 16'h0001 then 16'h8000 on consecutive cycles.
  -> The second start bit begins exactly on the clock after the first stop bit ends; tx shows no extra idle cycle.
- Overflow: write 6 words on consecutive cycles while the first frame runs.
  -> The first word pops; the next 4 fill the FIFO and full=1.
  -> The 6th write is rejected and overflow=1.
  -> Transmitted order: words 1-5; word 6 is never sent.
- Simultaneous push/pop: FIFO holds 1 word with the FSM at the end of STOP; write on that same edge.
  -> count stays 1 and the next frame starts immediately.
  -> Repeat with full=1: the write is rejected and overflow=1.
- Reset mid-frame: assert rst=0 halfway through DATA bit 7.
  -> tx=1 asynchronously; count=0, busy=0.
  -> After release, the previously buffered words are not sent.
